// File: rtl/iotile_config_loader.sv
// iotile_config_loader: assembles a byte-wide configuration stream into one
// IO tile configuration word, checks an XOR checksum and commits atomically.
module iotile_config_loader #(
    parameter int unsigned CONFIG_WIDTH = 24,
    parameter int unsigned WORD_WIDTH   = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [WORD_WIDTH-1:0]   cfg_data,
    input  logic                    cfg_valid,
    input  logic                    cfg_last,
    output logic                    cfg_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic                    config_valid,
    output logic [CONFIG_WIDTH-1:0] config_out
);

    localparam int unsigned NWORDS = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int unsigned CNT_W  = $clog2(NWORDS + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CONFIG_WIDTH-1:0] stage_q, stage_d;
    logic [WORD_WIDTH-1:0]   acc_q, acc_d;
    logic [CONFIG_WIDTH-1:0] config_q, config_d;
    logic                    cvalid_q, cvalid_d;

    logic beat_c;
    logic data_beat_c;

    // State, staging and committed-configuration registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            stage_q  <= '0;
            acc_q    <= '0;
            config_q <= '0;
            cvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stage_q  <= stage_d;
            acc_q    <= acc_d;
            config_q <= config_d;
            cvalid_q <= cvalid_d;
        end
    end

    // Beat acceptance and data/checksum beat classification
    always_comb begin
        beat_c      = cfg_valid && (state_q == ST_LOAD);
        data_beat_c = (cnt_q < CNT_W'(NWORDS));
    end

    // Next-state logic: load, verify, commit or flag error
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stage_d  = stage_q;
        acc_d    = acc_q;
        config_d = config_q;
        cvalid_d = cvalid_q;

        case (state_q)
            ST_IDLE, ST_ERROR: begin
                if (start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    stage_d = '0;
                    acc_d   = '0;
                end
            end
            ST_LOAD: begin
                if (beat_c) begin
                    if (data_beat_c) begin
                        // Lower words first; bits past CONFIG_WIDTH shift out
                        stage_d = stage_q
                                | (CONFIG_WIDTH'(cfg_data) << (32'(cnt_q) * WORD_WIDTH));
                        acc_d   = acc_q ^ cfg_data;
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cfg_last) begin
                            state_d = ST_ERROR;
                        end
                    end else if (cfg_last && (cfg_data == acc_q)) begin
                        state_d  = ST_COMMIT;
                        config_d = stage_q;
                        cvalid_d = 1'b1;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs decoded from the state register
    always_comb begin
        cfg_ready    = (state_q == ST_LOAD);
        busy         = (state_q == ST_LOAD) || (state_q == ST_COMMIT);
        done         = (state_q == ST_COMMIT);
        error        = (state_q == ST_ERROR);
        config_valid = cvalid_q;
        config_out   = config_q;
    end

endmodule

// File: tb/tb_iotile_config_loader.sv
// Testbench for iotile_config_loader: per-cycle vector table with a
// scoreboard queue, plus randomized loads with backpressure gaps.
module tb_iotile_config_loader;

    localparam logic [23:0] C1 = 24'h0F3CA5;
    localparam logic [23:0] C2 = 24'h030201;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  cfg_data;
    logic        cfg_valid;
    logic        cfg_last;
    logic        cfg_ready;
    logic        busy;
    logic        done;
    logic        error;
    logic        config_valid;
    logic [23:0] config_out;

    int checks = 0;
    int errors = 0;

    // in = {reset, start, cfg_valid, cfg_last}; ex = {ready, busy, done, error, config_valid}
    typedef struct {
        int          id;
        logic [3:0]  in;
        logic [7:0]  d;
        logic [4:0]  ex;
        logic [23:0] co;
    } row_t;

    row_t vec[$];
    row_t sb[$];

    always #5 clock = ~clock;

    iotile_config_loader #(.CONFIG_WIDTH(24), .WORD_WIDTH(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .cfg_data     (cfg_data),
        .cfg_valid    (cfg_valid),
        .cfg_last     (cfg_last),
        .cfg_ready    (cfg_ready),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .config_valid (config_valid),
        .config_out   (config_out)
    );

    task automatic add(input logic [3:0] in, input logic [7:0] d,
                       input logic [4:0] ex, input logic [23:0] co);
        row_t r;
        r.id = vec.size();
        r.in = in;
        r.d  = d;
        r.ex = ex;
        r.co = co;
        vec.push_back(r);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Scoreboard monitor: compare outputs mid-cycle against the queued expectation
    always @(negedge clock) begin
        row_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({cfg_ready, busy, done, error, config_valid} !== e.ex || config_out !== e.co) begin
                errors++;
                $display("FAIL row%0d got rdy/busy/done/err/cv=%b cout=%h want %b cout=%h",
                         e.id, {cfg_ready, busy, done, error, config_valid}, config_out, e.ex, e.co);
            end
        end
    end

    task automatic idle_inputs();
        reset     = 1'b0;
        start     = 1'b0;
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        cfg_data  = 8'h00;
    endtask

    // Randomized load with 0..2 idle cycles before each beat; checks latency and result
    task automatic rand_load(input int n);
        logic [7:0]  b [4];
        logic [23:0] exp_cfg;
        int          gaps;
        int          cyc;
        bit          seen;
        b[3] = 8'h00;
        for (int i = 0; i < 3; i++) begin
            b[i] = 8'($urandom);
            b[3] = b[3] ^ b[i];
        end
        exp_cfg = {b[2], b[1], b[0]};
        gaps = 0;
        cyc  = 0;
        @(posedge clock); #1;
        idle_inputs();
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int g;
            g = int'($urandom_range(0, 2));
            gaps += g;
            for (int k = 0; k < g; k++) begin
                @(posedge clock); #1; cyc++;
                idle_inputs();
                cfg_data = 8'hC3;
            end
            @(posedge clock); #1; cyc++;
            idle_inputs();
            cfg_valid = 1'b1;
            cfg_data  = b[i];
            cfg_last  = (i == 3);
        end
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(posedge clock); #1; cyc++;
            idle_inputs();
            seen = done;
        end
        check($sformatf("rand%0d_done_seen", n), 32'(seen), 32'd1);
        check($sformatf("rand%0d_latency", n), 32'(cyc), 32'(5 + gaps));
        check($sformatf("rand%0d_config_out", n), 32'(config_out), 32'(exp_cfg));
    endtask

    initial begin
        // reset state and nominal load
        add(4'b1000, 8'h00, 5'b00000, 24'h0);
        add(4'b0100, 8'h00, 5'b00000, 24'h0);
        add(4'b0010, 8'hA5, 5'b11000, 24'h0);
        add(4'b0010, 8'h3C, 5'b11000, 24'h0);
        add(4'b0010, 8'h0F, 5'b11000, 24'h0);
        add(4'b0011, 8'h96, 5'b11000, 24'h0);
        add(4'b0000, 8'h00, 5'b01101, C1);
        add(4'b0000, 8'h00, 5'b00001, C1);
        // bad checksum; beat offered in ERROR is ignored
        add(4'b0100, 8'h00, 5'b00001, C1);
        add(4'b0010, 8'h11, 5'b11001, C1);
        add(4'b0010, 8'h22, 5'b11001, C1);
        add(4'b0010, 8'h44, 5'b11001, C1);
        add(4'b0011, 8'hFF, 5'b11001, C1);
        add(4'b0000, 8'h00, 5'b00011, C1);
        add(4'b0011, 8'h96, 5'b00011, C1);
        // early last, then a clean load
        add(4'b0100, 8'h00, 5'b00011, C1);
        add(4'b0011, 8'h11, 5'b11001, C1);
        add(4'b0000, 8'h00, 5'b00011, C1);
        add(4'b0100, 8'h00, 5'b00011, C1);
        add(4'b0010, 8'h01, 5'b11001, C1);
        add(4'b0010, 8'h02, 5'b11001, C1);
        add(4'b0010, 8'h03, 5'b11001, C1);
        add(4'b0011, 8'h00, 5'b11001, C1);
        add(4'b0000, 8'h00, 5'b01101, C2);
        add(4'b0000, 8'h00, 5'b00001, C2);
        // backpressure: idle cycle (valid=0, junk data/last) between beats
        add(4'b0100, 8'h00, 5'b00001, C2);
        add(4'b0010, 8'hA5, 5'b11001, C2);
        add(4'b0001, 8'hEE, 5'b11001, C2);
        add(4'b0010, 8'h3C, 5'b11001, C2);
        add(4'b0001, 8'hEE, 5'b11001, C2);
        add(4'b0010, 8'h0F, 5'b11001, C2);
        add(4'b0001, 8'hEE, 5'b11001, C2);
        add(4'b0011, 8'h96, 5'b11001, C2);
        add(4'b0000, 8'h00, 5'b01101, C1);
        add(4'b0000, 8'h00, 5'b00001, C1);
        // reset mid-load, then beats without start are not accepted
        add(4'b0100, 8'h00, 5'b00001, C1);
        add(4'b0010, 8'hA5, 5'b11001, C1);
        add(4'b0010, 8'h3C, 5'b11001, C1);
        add(4'b1000, 8'h00, 5'b11001, C1);
        add(4'b0010, 8'h0F, 5'b00000, 24'h0);
        add(4'b0011, 8'h96, 5'b00000, 24'h0);
        add(4'b0000, 8'h00, 5'b00000, 24'h0);
        // start together with reset: reset wins
        add(4'b1100, 8'h00, 5'b00000, 24'h0);
        add(4'b0010, 8'hA5, 5'b00000, 24'h0);
        // nominal load with start ignored in LOAD and COMMIT
        add(4'b0100, 8'h00, 5'b00000, 24'h0);
        add(4'b0010, 8'hA5, 5'b11000, 24'h0);
        add(4'b0110, 8'h3C, 5'b11000, 24'h0);
        add(4'b0010, 8'h0F, 5'b11000, 24'h0);
        add(4'b0011, 8'h96, 5'b11000, 24'h0);
        add(4'b0100, 8'h00, 5'b01101, C1);
        add(4'b0000, 8'h00, 5'b00001, C1);
        // missing last on a correct checksum
        add(4'b0100, 8'h00, 5'b00001, C1);
        add(4'b0010, 8'h11, 5'b11001, C1);
        add(4'b0010, 8'h22, 5'b11001, C1);
        add(4'b0010, 8'h44, 5'b11001, C1);
        add(4'b0010, 8'h77, 5'b11001, C1);
        add(4'b0000, 8'h00, 5'b00011, C1);
        add(4'b0100, 8'h00, 5'b00011, C1);
        add(4'b0000, 8'h00, 5'b11001, C1);
        add(4'b0000, 8'h00, 5'b11001, C1);

        idle_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clock);

        foreach (vec[i]) begin
            @(posedge clock); #1;
            reset     = vec[i].in[3];
            start     = vec[i].in[2];
            cfg_valid = vec[i].in[1];
            cfg_last  = vec[i].in[0];
            cfg_data  = vec[i].d;
            sb.push_back(vec[i]);
        end
        @(posedge clock); #1;
        idle_inputs();
        @(negedge clock);

        // leave the stalled load via reset, then randomized loads
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        idle_inputs();
        check("post_reset_config_valid", 32'(config_valid), 32'd0);
        check("post_reset_busy", 32'(busy), 32'd0);
        for (int n = 0; n < 4; n++) begin
            rand_load(n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
